frame_renderer: RTL and testbench

Reads the game state published by the logic handler (ship positions, enemy bullet grid, ship health) and walks the 160x120 screen once per frame. For each pixel it emits coordinates, a 3-bit colour and a plot strobe to the VGA adapter. It sits between the logic handler and the VGA adapter, and the top-level FSM triggers it once per frame.

---
 rtl/starflux_pkg.sv | 35 +++
 rtl/frame_renderer_if.sv | 28 ++
 rtl/frame_renderer_raster_counter.sv | 45 ++++
 rtl/frame_renderer.sv | 134 +++++++++++++
 tb/tb_frame_renderer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/starflux_pkg.sv
// starflux_pkg: shared screen geometry, colour codes, renderer state type,
// snapshot struct and a span hit helper used by the frame renderer.
package starflux_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_USER   = 3'b010;
  localparam logic [2:0] COL_ENEMY  = 3'b101;
  localparam logic [2:0] COL_BULLET = 3'b111;
  localparam logic [2:0] COL_HEALTH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_FINISH
  } rend_state_e;

  // Ship positions captured when a frame is accepted.
  typedef struct packed {
    logic [7:0] ux;
    logic [6:0] uy;
    logic [7:0] ex;
    logic [6:0] ey;
  } snap_t;

  // p in [s, s+len-1], evaluated in 9 bits so the sprite end never wraps;
  // anything past the screen edge simply never matches a scanned pixel.
  function automatic logic span_hit(input logic [8:0] p, input logic [8:0] s,
                                    input logic [8:0] len);
    return (p >= s) && (p <= s + len - 9'd1);
  endfunction

endpackage

// File: rtl/frame_renderer_if.sv
// frame_renderer_if: game-state inputs and VGA pixel outputs of the renderer.
//   master: frame FSM / logic handler / VGA side (drives state, reads pixels)
//   slave : frame_renderer
interface frame_renderer_if;
  logic           drawEn;
  logic [7:0]     user_x;
  logic [6:0]     user_y;
  logic [7:0]     enemy_x;
  logic [6:0]     enemy_y;
  logic [19199:0] enem_grid;
  logic [3:0]     ship_health;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output drawEn, user_x, user_y, enemy_x, enemy_y, enem_grid, ship_health,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  drawEn, user_x, user_y, enemy_x, enemy_y, enem_grid, ship_health,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_renderer_raster_counter.sv
// raster_counter: raster x/y scan counter for the 160x120 screen.
//   clk, reset : clock, async active-high reset
//   clr_i      : return to (0,0) (wins over en_i)
//   en_i       : advance one pixel, x fastest
//   x_o, y_o   : current pixel
//   last_o     : current pixel is (159,119)
module raster_counter
  import starflux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       last_o
);

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic       x_last;

  assign x_last = (x_q == 8'(SCREEN_W - 1));
  assign last_o = x_last && (y_q == 7'(SCREEN_H - 1));
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en_i) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= last_o ? '0 : y_q + 7'd1;
      end else begin
        x_q <= x_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_renderer.sv
// frame_renderer: scans the 160x120 screen once per drawEn request and emits
// one coloured pixel per cycle to the VGA adapter.
//   clk, reset : clock, async active-high reset
//   bus        : frame_renderer_if.slave (drawEn, ship positions, bullet grid,
//                ship_health in; x, y, colour, plot, busy, done out)
// Optional feature macro: HEALTH_BAR_EN (health bar in rows 0..1).
// Pipeline: counter issues pixel k, stage 1 registers its coordinates, the
// output stage registers colour; pixel k shows on the outputs after T+2+k.
module frame_renderer
  import starflux_pkg::*;
#(
  parameter int SHIP_W = 8,
  parameter int SHIP_H = 8
) (
  input  logic           clk,
  input  logic           reset,
  frame_renderer_if.slave bus
);

  rend_state_e state_q, state_d;
  snap_t       snap_q;
  logic        accept;
  logic        run_q;
  logic [7:0]  cx;
  logic [6:0]  cy;
  logic        clast;
  logic [7:0]  s1_x_q;
  logic [6:0]  s1_y_q;
  logic [1:0]  vld_pipe_q;   // [0] stage 1 valid, [1] output valid (plot)
  logic [1:0]  last_pipe_q;  // last pixel marker travelling with vld_pipe_q
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  colour_q;
  logic        busy_q, done_q;
  logic [14:0] gidx;
  logic        u_hit, e_hit;
  logic [2:0]  pix_col;

  assign accept = (state_q == ST_IDLE) && bus.drawEn;

  raster_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .en_i   (run_q),
    .x_o    (cx),
    .y_o    (cy),
    .last_o (clast)
  );

  // FSM: DRAW holds until the last pixel is on the outputs, so FINISH (and
  // done) lands in the cycle right after the final plot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.drawEn)     state_d = ST_DRAW;
      ST_DRAW:   if (last_pipe_q[1]) state_d = ST_FINISH;
      ST_FINISH:                     state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Colour of the stage-1 pixel.
  assign gidx  = 15'(s1_y_q) * 15'(SCREEN_W) + 15'(s1_x_q);
  assign u_hit = span_hit({1'b0, s1_x_q}, {1'b0, snap_q.ux}, 9'(SHIP_W)) &&
                 span_hit({2'b0, s1_y_q}, {2'b0, snap_q.uy}, 9'(SHIP_H));
  assign e_hit = span_hit({1'b0, s1_x_q}, {1'b0, snap_q.ex}, 9'(SHIP_W)) &&
                 span_hit({2'b0, s1_y_q}, {2'b0, snap_q.ey}, 9'(SHIP_H));

`ifdef HEALTH_BAR_EN
  logic [3:0] hp_q;
  logic       hb_hit;
  // Bar is 4 pixels per health point across rows 0..1.
  assign hb_hit = (s1_y_q < 7'd2) && (s1_x_q < {2'b0, hp_q, 2'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       hp_q <= '0;
    else if (accept) hp_q <= bus.ship_health;
  end
`endif

  always_comb begin
    pix_col = COL_BG;
    if (bus.enem_grid[gidx]) pix_col = COL_BULLET;
    if (e_hit)               pix_col = COL_ENEMY;
    if (u_hit)               pix_col = COL_USER;
`ifdef HEALTH_BAR_EN
    if (hb_hit)              pix_col = COL_HEALTH;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      run_q       <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= COL_BG;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        snap_q <= '{ux: bus.user_x, uy: bus.user_y,
                    ex: bus.enemy_x, ey: bus.enemy_y};
      if (accept)              run_q <= 1'b1;
      else if (run_q && clast) run_q <= 1'b0;
      s1_x_q      <= cx;
      s1_y_q      <= cy;
      vld_pipe_q  <= {vld_pipe_q[0], run_q};
      last_pipe_q <= {last_pipe_q[0], run_q & clast};
      if (vld_pipe_q[0]) begin
        x_q      <= s1_x_q;
        y_q      <= s1_y_q;
        colour_q <= pix_col;
      end
      busy_q <= (state_d == ST_DRAW);
      done_q <= (state_d == ST_FINISH);
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = vld_pipe_q[1];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: randomized frames checked pixel-by-pixel against a
// screen-level reference model, plus directed spot checks.
module tb_frame_renderer;

  localparam int W = 160, H = 120, NPIX = W * H, SW = 8, SH = 8;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  frame_renderer_if bus ();

  frame_renderer #(.SHIP_W(SW), .SHIP_H(SH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [NPIX-1:0] g;
  int s_ux, s_uy, s_ex, s_ey, s_h;
  logic [2:0] cap [0:NPIX-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Screen-level reference: what colour should (px,py) be for the frame's
  // snapshot and grid.
  function automatic logic [2:0] ref_col(input int px, input int py);
`ifdef HEALTH_BAR_EN
    if (py < 2 && px < 4 * s_h) return 3'b100;
`endif
    if (px >= s_ux && px < s_ux + SW && py >= s_uy && py < s_uy + SH) return 3'b010;
    if (px >= s_ex && px < s_ex + SW && py >= s_ey && py < s_ey + SH) return 3'b101;
    if (g[py * W + px]) return 3'b111;
    return 3'b000;
  endfunction

  function automatic int pidx(input int px, input int py);
    return py * W + px;
  endfunction

  task automatic set_state(input int ux, input int uy, input int ex, input int ey, input int h);
    s_ux = ux; s_uy = uy; s_ex = ex; s_ey = ey; s_h = h;
    bus.user_x      = 8'(ux);
    bus.user_y      = 7'(uy);
    bus.enemy_x     = 8'(ex);
    bus.enemy_y     = 7'(ey);
    bus.ship_health = 4'(h);
    bus.enem_grid   = g;
  endtask

  task automatic rand_grid();
    for (int i = 0; i < NPIX; i++) g[i] = ($urandom_range(0, 7) == 0);
  endtask

  // Runs one frame. abort_at>0 asserts reset after that cycle's check;
  // poke adds ignored drawEn pulses and mid-frame input changes.
  task automatic frame(input int abort_at, input bit poke);
    int k;
    @(negedge clk);
    bus.drawEn = 1'b1;
    @(negedge clk);                    // after edge T
    bus.drawEn = 1'b0;
    chk("t0_busy", 32'({bus.busy, bus.plot, bus.done}), 32'b100);
    for (int c = 1; c <= NPIX + 3; c++) begin
      @(negedge clk);                  // after edge T+c
      if (c == 1) begin
        chk("t1_idle_pipe", 32'({bus.busy, bus.plot, bus.done}), 32'b100);
      end else if (c <= NPIX + 1) begin
        k = c - 2;
        cap[k] = bus.colour;
        chk($sformatf("pix%0d", k),
            32'({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}),
            32'({3'b110, 8'(k % W), 7'(k / W), ref_col(k % W, k / W)}));
      end else if (c == NPIX + 2) begin
        chk("done_cyc", 32'({bus.done, bus.plot, bus.busy}), 32'b100);
      end else begin
        chk("after_done", 32'({bus.done, bus.plot, bus.busy}), 32'b000);
      end
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_async", 32'({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_no_done", 32'({bus.done, bus.busy, bus.plot}), 32'd0);
        end
        return;
      end
      bus.drawEn = poke && (c == 4999 || c == NPIX + 2);
      if (poke && c == 3000) begin
        bus.user_x      = 8'($urandom);
        bus.user_y      = 7'($urandom);
        bus.enemy_x     = 8'($urandom);
        bus.enemy_y     = 7'($urandom);
        bus.ship_health = 4'($urandom);
      end
    end
    @(negedge clk);
    chk("no_restart", 32'({bus.busy, bus.plot, bus.done}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.drawEn = 1'b0;
    g = '0;
    set_state(0, 0, 0, 0, 0);
    #1;
    chk("rst_out", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_out", 32'({bus.plot, bus.busy, bus.done}), 32'd0);

    // Frame 1: everything zero, empty grid.
    frame(0, 1'b0);
    chk("f1_00", 32'(cap[pidx(0, 0)]), 32'b010);
    chk("f1_77", 32'(cap[pidx(7, 7)]), 32'b010);
    chk("f1_80", 32'(cap[pidx(8, 0)]), 32'b000);
    chk("f1_last", 32'(cap[pidx(159, 119)]), 32'b000);

    // Frame 2: overlapping ships, a bullet under both, ignored drawEns,
    // mid-frame input changes.
    rand_grid();
    g[pidx(105, 55)] = 1'b1;
    set_state(100, 50, 104, 54, $urandom_range(0, 15));
    frame(0, 1'b1);
    chk("f2_u", 32'(cap[pidx(100, 50)]), 32'b010);
    chk("f2_ovl", 32'(cap[pidx(105, 55)]), 32'b010);
    chk("f2_e1", 32'(cap[pidx(111, 61)]), 32'b101);
    chk("f2_e2", 32'(cap[pidx(108, 58)]), 32'b101);

    // Frame 3: accepted right after the previous one; ship clipped at right edge.
    rand_grid();
    for (int yy = 20; yy < 28; yy++)
      for (int xx = 0; xx < 4; xx++) g[pidx(xx, yy)] = 1'b0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 13; xx++) g[pidx(xx, yy)] = 1'b0;
    set_state(156, 20, 40, 80, 3);
    frame(0, 1'b0);
    chk("f3_clip0", 32'(cap[pidx(156, 20)]), 32'b010);
    chk("f3_clip1", 32'(cap[pidx(159, 27)]), 32'b010);
    chk("f3_nowrap0", 32'(cap[pidx(0, 20)]), 32'b000);
    chk("f3_nowrap1", 32'(cap[pidx(3, 27)]), 32'b000);
`ifdef HEALTH_BAR_EN
    chk("f3_hb0", 32'(cap[pidx(0, 0)]), 32'b100);
    chk("f3_hb11", 32'(cap[pidx(11, 1)]), 32'b100);
    chk("f3_hb12", 32'(cap[pidx(12, 0)]), 32'b000);
`endif

    // Frame 4: reset mid-frame.
    rand_grid();
    set_state($urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 15));
    frame(10000, 1'b0);

    // Frame 5: fresh random frame after the abort, scan restarts at (0,0).
    rand_grid();
    set_state($urandom_range(0, 159), $urandom_range(0, 119),
              $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 15));
    frame(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
